reg_bank_write_arbiter: RTL and testbench
=========================================

Name: reg_bank_write_arbiter

Overview:
- Sequences the single load port of a DEPTH-word register bank built from the team's 1-bit load-enable register cells.
- Shares that port between two requesters (A, B) with round-robin arbitration.
- Runs a hardware clear sequence that writes zero to every word, one word per cycle.
- Drives the bank's per-word load-enable lines and shared data bus; the bank clocks on the same C.

Parameters:
- WIDTH, 8, data bits per word.
- DEPTH, 4, number of words in the bank.
- ADDR_W, 2, address width; must satisfy 2**ADDR_W >= DEPTH.

Ports:
- C  in  1  clock; all state changes on rising edge.
- R  in  1  asynchronous active-high reset.
- reqA  in  1  requester A write request; held until ackA seen.
- addrA  in  ADDR_W  requester A target word.
- dataA  in  WIDTH  requester A write data.
- reqB  in  1  requester B write request.
- addrB  in  ADDR_W  requester B target word.
- dataB  in  WIDTH  requester B write data.
- clr  in  1  start clear sequence; sampled level.
- L  out  DEPTH  one-hot word load enables to bank, registered.
- D  out  WIDTH  data to bank, registered.
- ackA  out  1  one-cycle pulse; A's write is on L/D this cycle.
- ackB  out  1  one-cycle pulse; B's write is on L/D this cycle.
- busy  out  1  high while the clear sequence runs.

Behaviour:
- Reset (async, any time, including mid-clear): L=0, D=0, ackA=0, ackB=0, busy=0, state=IDLE, cnt=0, last=B (so A wins the first tie). Mid-clear reset abandons the clear; words already cleared stay cleared.
- States: IDLE (arbitrate writes) and CLEAR (walk the bank).
- IDLE, at each edge, clr sampled high:
  - go to CLEAR; cnt=0; busy=1.
  - Outputs this edge: L=onehot(0), D=0, no ack.
  - Pending requests wait; last is unchanged.
- IDLE, clr low:
  - Eligible A = reqA and not ackA (the requester acked this cycle is masked for one cycle, preventing a double write from a registered requester). Same rule for B.
  - Only one eligible: grant it.
  - Both eligible: grant the one != last.
  - On grant: L=onehot(addrX), D=dataX, ackX=1, last=X, all registered at that edge.
  - No grant: L=0, D holds its previous value, acks=0.
- CLEAR, each edge:
  - cnt<DEPTH-1: cnt++, L=onehot(cnt+1), D=0, busy=1.
  - cnt=DEPTH-1: L=0, busy=0, cnt=0, return to IDLE; normal arbitration resumes at the next edge.
  - clr and all requests are ignored in CLEAR; acks stay 0.
- Clear latency: DEPTH cycles of L activity, one word per cycle in ascending order.
- Address >= DEPTH: L=0 (no word loaded), but ack still pulses; the write is dropped silently.
- Throughput:
  - one write per cycle overall;
  - a single requester gets at most one write per 2 cycles (ack masking);
  - two saturating requesters alternate A,B,A,B every cycle.
- At most one L bit is high on any cycle; ackA and ackB are never high together.
- D changes only on a grant or during CLEAR.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=0, ST_CLEAR=1;
  - requester IDs RQ_A=0, RQ_B=1;
  - reset value of last (RQ_B).
- Sub-module: onehot_addr_decoder (ADDR_W in, DEPTH out, all-zero for out-of-range). Used for both the grant path and the clear counter.
- Arbitration, mask and FSM stay in the top module.

Test Plan:
- Reset then single write: R pulse; reqA=1, addrA=2, dataA=8'hA5 held until ack → next edge L=4'b0100, D=8'hA5, ackA=1 for exactly one cycle. If reqA is still high the following cycle, no second write (L=0).
- Tie and round-robin: reqA and reqB both held high with addrA=0/8'h11 and addrB=3/8'h33 → grants A, B, A, B on consecutive edges; L alternates 0001/1000; acks never overlap.
- Clear: clr=1 for one cycle from IDLE → busy=1 for 4 cycles; L=0001,0010,0100,1000 with D=0; then busy=0, L=0. A bank of REG1 cells preset to all ones reads all zero afterwards.
- Clear versus request: clr and reqB (addr 1, 8'h5A) on the same edge → clear runs first with ackB=0 throughout; the first edge after busy falls gives ackB=1, L=0010, D=8'h5A.
- Reset mid-clear: assert R during the third clear cycle → L=0 and busy=0 immediately, without waiting for C; after release the next tie grants A first.
- Out-of-range address: with DEPTH=3, reqA to addr 3 → ackA=1, L=000, bank unchanged.

Source files
------------

// File: rtl/reg_bank_write_arbiter_pkg.sv
// Shared definitions for the register-bank write arbiter.
//   state_t  : FSM state encoding (idle arbitration / clear walk)
//   rq_t     : requester identifiers used by the round-robin pointer
//   LAST_RST : reset value of the round-robin pointer, so A wins the first tie
package reg_bank_write_arbiter_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   typedef enum logic {
      RQ_A = 1'b0,
      RQ_B = 1'b1
   } rq_t;

   localparam rq_t LAST_RST = RQ_B;

endpackage

// File: rtl/reg_bank_write_arbiter_onehot_addr_decoder.sv
// Binary word address to one-hot load-enable decoder.
//   addr   : word address, ADDR_W bits
//   onehot : DEPTH load enables; all zero when addr >= DEPTH
module reg_bank_write_arbiter_onehot_addr_decoder #(
   parameter int ADDR_W = 2,
   parameter int DEPTH  = 4
) (
   input  logic [ADDR_W-1:0] addr,
   output logic [DEPTH-1:0]  onehot
);

   always_comb begin
      onehot = '0;
      for (int i = 0; i < DEPTH; i++) begin
         onehot[i] = (addr == ADDR_W'(i));
      end
   end

endmodule

// File: rtl/reg_bank_write_arbiter.sv
// Write sequencer for a DEPTH-word register bank with a single load port.
// Two requesters share the port under round-robin arbitration; a clear
// request walks the bank writing zero to one word per cycle.
//   C            : clock, rising edge
//   R            : asynchronous active-high reset
//   reqA/addrA/dataA, reqB/addrB/dataB : requester write ports (held until ack)
//   clr          : start clear walk (level sampled in IDLE)
//   L            : registered one-hot word load enables to the bank
//   D            : registered data bus to the bank
//   ackA/ackB    : one-cycle pulse, that requester's write is on L/D now
//   busy         : high while the clear walk drives L
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | arbitrate A/B writes, or launch a clear on clr
// ST_CLEAR | drive zero into word cnt+1 each cycle; exit after last word
module reg_bank_write_arbiter
   import reg_bank_write_arbiter_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic              C,
   input  logic              R,
   input  logic              reqA,
   input  logic [ADDR_W-1:0] addrA,
   input  logic [WIDTH-1:0]  dataA,
   input  logic              reqB,
   input  logic [ADDR_W-1:0] addrB,
   input  logic [WIDTH-1:0]  dataB,
   input  logic              clr,
   output logic [DEPTH-1:0]  L,
   output logic [WIDTH-1:0]  D,
   output logic              ackA,
   output logic              ackB,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] cnt, cnt_nxt;
   rq_t               last, last_nxt;
   logic [DEPTH-1:0]  l_nxt;
   logic [WIDTH-1:0]  d_nxt;
   logic              ack_a_nxt, ack_b_nxt, busy_nxt;

   logic              elig_a, elig_b;
   logic              grant_a, grant_b;
   logic [ADDR_W-1:0] grant_addr;
   logic [ADDR_W-1:0] clear_idx;
   logic [DEPTH-1:0]  grant_onehot;
   logic [DEPTH-1:0]  clear_onehot;

   // A requester that was acked on this cycle is still showing the same
   // request (it only sees ack at the next edge), so mask it for one cycle.
   assign elig_a  = reqA & ~ackA;
   assign elig_b  = reqB & ~ackB;
   assign grant_a = elig_a & (~elig_b | (last == RQ_B));
   assign grant_b = elig_b & ~grant_a;

   assign grant_addr = grant_a ? addrA : addrB;

   // Entering the walk loads word 0; inside the walk the next word is cnt+1.
   assign clear_idx = (state == ST_IDLE) ? '0 : (cnt + ADDR_W'(1));

   reg_bank_write_arbiter_onehot_addr_decoder #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_grant_dec (
      .addr   (grant_addr),
      .onehot (grant_onehot)
   );

   reg_bank_write_arbiter_onehot_addr_decoder #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_clear_dec (
      .addr   (clear_idx),
      .onehot (clear_onehot)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      last_nxt  = last;
      l_nxt     = '0;
      d_nxt     = D;
      ack_a_nxt = 1'b0;
      ack_b_nxt = 1'b0;
      busy_nxt  = busy;

      case (state)
         ST_IDLE: begin
            if (clr) begin
               // Pending requests wait; the round-robin pointer is untouched.
               state_nxt = ST_CLEAR;
               cnt_nxt   = '0;
               busy_nxt  = 1'b1;
               l_nxt     = clear_onehot;
               d_nxt     = '0;
            end else if (grant_a) begin
               l_nxt     = grant_onehot;
               d_nxt     = dataA;
               ack_a_nxt = 1'b1;
               last_nxt  = RQ_A;
            end else if (grant_b) begin
               l_nxt     = grant_onehot;
               d_nxt     = dataB;
               ack_b_nxt = 1'b1;
               last_nxt  = RQ_B;
            end
         end

         ST_CLEAR: begin
            d_nxt = '0;
            if (cnt == CNT_LAST) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
               busy_nxt  = 1'b0;
            end else begin
               cnt_nxt  = cnt + ADDR_W'(1);
               l_nxt    = clear_onehot;
               busy_nxt = 1'b1;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge C or posedge R) begin
      if (R) begin
         state <= ST_IDLE;
         cnt   <= '0;
         last  <= LAST_RST;
         L     <= '0;
         D     <= '0;
         ackA  <= 1'b0;
         ackB  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         last  <= last_nxt;
         L     <= l_nxt;
         D     <= d_nxt;
         ackA  <= ack_a_nxt;
         ackB  <= ack_b_nxt;
         busy  <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Bench for reg_bank_write_arbiter: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_reg_bank_write_arbiter;

   localparam int WIDTH  = 8;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 2;

   logic             C = 1'b0;
   logic             R;
   logic             reqA, reqB, clr;
   logic [1:0]       addrA, addrB;
   logic [7:0]       dataA, dataB;
   logic [3:0]       L;
   logic [7:0]       D;
   logic             ackA, ackB, busy;
   logic [2:0]       L3;
   logic [7:0]       D3;
   logic             ackA3, ackB3, busy3;
   logic             preset;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 C = ~C;

   reg_bank_write_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dut (
      .C(C), .R(R),
      .reqA(reqA), .addrA(addrA), .dataA(dataA),
      .reqB(reqB), .addrB(addrB), .dataB(dataB),
      .clr(clr), .L(L), .D(D), .ackA(ackA), .ackB(ackB), .busy(busy)
   );

   // Three-word variant so address 3 is out of range.
   reg_bank_write_arbiter #(.WIDTH(WIDTH), .DEPTH(3), .ADDR_W(ADDR_W)) u_dut3 (
      .C(C), .R(R),
      .reqA(reqA), .addrA(addrA), .dataA(dataA),
      .reqB(reqB), .addrB(addrB), .dataB(dataB),
      .clr(clr), .L(L3), .D(D3), .ackA(ackA3), .ackB(ackB3), .busy(busy3)
   );

   // Behavioural bank of load-enable cells, preset to all ones during reset.
   logic [7:0] bank [DEPTH];
   always @(posedge C) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (preset)    bank[i] <= 8'hFF;
         else if (L[i]) bank[i] <= D;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic ra, input logic [1:0] aa, input logic [7:0] da,
                        input logic rb, input logic [1:0] ab, input logic [7:0] db,
                        input logic cl);
      reqA = ra; addrA = aa; dataA = da;
      reqB = rb; addrB = ab; dataB = db;
      clr  = cl;
   endtask

   task automatic tick();
      @(posedge C);
      @(negedge C);
   endtask

   task automatic do_reset(input logic check);
      drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0);
      R = 1'b1;
      preset = 1'b1;
      #1;
      if (check) begin
         chk("rst_L", 32'(L), 32'h0);
         chk("rst_D", 32'(D), 32'h0);
         chk("rst_ack", 32'({ackA, ackB}), 32'h0);
         chk("rst_busy", 32'(busy), 32'h0);
      end
      @(negedge C);
      R = 1'b0;
      preset = 1'b0;
   endtask

   // ---------------- behavioural reference model ----------------
   // Clear walk is a queue of word indices still to be zeroed; -1 marks the
   // closing cycle where nothing is loaded and busy drops.
   int         m_q[$];
   int         m_last;          // 0 = A, 1 = B
   logic       m_pa, m_pb;
   logic [3:0] mL;
   logic [7:0] mD;
   logic       m_busy;
   logic [7:0] m_bank [DEPTH];

   function automatic void model_reset();
      m_q.delete();
      m_last = 1;
      m_pa = 1'b0; m_pb = 1'b0;
      mL = '0; mD = '0; m_busy = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_bank[i] = 8'hFF;
   endfunction

   function automatic void model_step();
      int g;
      int a;
      int w;
      g = -1;
      mL = '0;
      if (m_q.size() > 0) begin
         w = m_q.pop_front();
         if (w >= 0) mL = 4'(1 << w);
         mD = 8'h00;
         m_busy = (w >= 0);
         m_pa = 1'b0; m_pb = 1'b0;
      end else if (clr) begin
         for (int i = 1; i < DEPTH; i++) m_q.push_back(i);
         m_q.push_back(-1);
         mL = 4'b0001;
         mD = 8'h00;
         m_busy = 1'b1;
         m_pa = 1'b0; m_pb = 1'b0;
      end else begin
         if (reqA && !m_pa && reqB && !m_pb) g = (m_last == 0) ? 1 : 0;
         else if (reqA && !m_pa)             g = 0;
         else if (reqB && !m_pb)             g = 1;
         m_pa = (g == 0);
         m_pb = (g == 1);
         if (g >= 0) begin
            m_last = g;
            a  = (g == 0) ? int'(addrA) : int'(addrB);
            mD = (g == 0) ? dataA : dataB;
            if (a < DEPTH) mL = 4'(1 << a);
         end
      end
      for (int i = 0; i < DEPTH; i++) if (mL[i]) m_bank[i] = mD;
   endfunction

   // ---------------- directed vector table ----------------
   typedef struct {
      logic       ra;  logic [1:0] aa; logic [7:0] da;
      logic       rb;  logic [1:0] ab; logic [7:0] db;
      logic       cl;
      logic [3:0] el;  logic [7:0] ed;
      logic       eaa; logic       eab; logic       eb;
   } vec_t;

   vec_t tbl [19];

   initial begin
      // single write, then held request masked
      tbl[0]  = '{1'b1, 2'd2, 8'hA5, 1'b0, 2'd0, 8'h00, 1'b0, 4'b0100, 8'hA5, 1'b1, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 2'd2, 8'hA5, 1'b0, 2'd0, 8'h00, 1'b0, 4'b0000, 8'hA5, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 4'b0000, 8'hA5, 1'b0, 1'b0, 1'b0};
      // tie: last grant was A, so B first, then strict alternation
      tbl[3]  = '{1'b1, 2'd0, 8'h11, 1'b1, 2'd3, 8'h33, 1'b0, 4'b1000, 8'h33, 1'b0, 1'b1, 1'b0};
      tbl[4]  = '{1'b1, 2'd0, 8'h11, 1'b1, 2'd3, 8'h33, 1'b0, 4'b0001, 8'h11, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 2'd0, 8'h11, 1'b1, 2'd3, 8'h33, 1'b0, 4'b1000, 8'h33, 1'b0, 1'b1, 1'b0};
      tbl[6]  = '{1'b1, 2'd0, 8'h11, 1'b1, 2'd3, 8'h33, 1'b0, 4'b0001, 8'h11, 1'b1, 1'b0, 1'b0};
      // clear walk
      tbl[7]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 4'b0001, 8'h00, 1'b0, 1'b0, 1'b1};
      tbl[8]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 4'b0010, 8'h00, 1'b0, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 4'b0100, 8'h00, 1'b0, 1'b0, 1'b1};
      tbl[10] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 4'b1000, 8'h00, 1'b0, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0};
      // clear versus request on the same edge
      tbl[12] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 8'h5A, 1'b1, 4'b0001, 8'h00, 1'b0, 1'b0, 1'b1};
      tbl[13] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 8'h5A, 1'b0, 4'b0010, 8'h00, 1'b0, 1'b0, 1'b1};
      tbl[14] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 8'h5A, 1'b0, 4'b0100, 8'h00, 1'b0, 1'b0, 1'b1};
      tbl[15] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 8'h5A, 1'b0, 4'b1000, 8'h00, 1'b0, 1'b0, 1'b1};
      tbl[16] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 8'h5A, 1'b0, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[17] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 8'h5A, 1'b0, 4'b0010, 8'h5A, 1'b0, 1'b1, 1'b0};
      tbl[18] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 4'b0000, 8'h5A, 1'b0, 1'b0, 1'b0};

      preset = 1'b0;
      do_reset(1'b1);

      for (int i = 0; i < 19; i++) begin
         drive(tbl[i].ra, tbl[i].aa, tbl[i].da, tbl[i].rb, tbl[i].ab, tbl[i].db, tbl[i].cl);
         tick();
         chk($sformatf("tbl%0d_L", i),    32'(L),    32'(tbl[i].el));
         chk($sformatf("tbl%0d_D", i),    32'(D),    32'(tbl[i].ed));
         chk($sformatf("tbl%0d_ackA", i), 32'(ackA), 32'(tbl[i].eaa));
         chk($sformatf("tbl%0d_ackB", i), 32'(ackB), 32'(tbl[i].eab));
         chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].eb));
      end
      // bank preset to ones, cleared twice, then word 1 written with 5A
      chk("tbl_bank0", 32'(bank[0]), 32'h00);
      chk("tbl_bank1", 32'(bank[1]), 32'h5A);
      chk("tbl_bank2", 32'(bank[2]), 32'h00);
      chk("tbl_bank3", 32'(bank[3]), 32'h00);

      // reset in the third clear cycle, then the tie goes to A
      do_reset(1'b0);
      drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1);
      tick();
      drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0);
      tick();
      tick();
      chk("midclr_L_before", 32'(L), 32'b0100);
      R = 1'b1;
      #1;
      chk("midclr_L_async", 32'(L), 32'h0);
      chk("midclr_busy_async", 32'(busy), 32'h0);
      @(negedge C);
      R = 1'b0;
      drive(1'b1, 2'd0, 8'h11, 1'b1, 2'd3, 8'h33, 1'b0);
      tick();
      chk("midclr_tie_ackA", 32'(ackA), 32'h1);
      chk("midclr_tie_ackB", 32'(ackB), 32'h0);
      chk("midclr_tie_L", 32'(L), 32'b0001);

      // out-of-range address on the three-word instance
      do_reset(1'b0);
      drive(1'b1, 2'd3, 8'h77, 1'b0, 2'd0, 8'h00, 1'b0);
      tick();
      chk("oor_ackA", 32'(ackA3), 32'h1);
      chk("oor_L", 32'(L3), 32'h0);
      chk("oor_D", 32'(D3), 32'h77);
      chk("inrange_L", 32'(L), 32'b1000);

      // randomized traffic against the model
      do_reset(1'b0);
      model_reset();
      for (int n = 0; n < 400; n++) begin
         drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom),
               1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom),
               1'($urandom_range(0, 15) == 0));
         model_step();
         tick();
         chk("rnd_L", 32'(L), 32'(mL));
         chk("rnd_D", 32'(D), 32'(mD));
         chk("rnd_acks", 32'({ackA, ackB}), 32'({m_pa, m_pb}));
         chk("rnd_busy", 32'(busy), 32'(m_busy));
         if (ackA && ackB) chk("rnd_ack_overlap", 32'({ackA, ackB}), 32'h0);
      end
      // drain any clear walk so the last load has reached the bank
      for (int n = 0; n < DEPTH + 3; n++) begin
         drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0);
         model_step();
         tick();
         chk("drain_L", 32'(L), 32'(mL));
         chk("drain_busy", 32'(busy), 32'(m_busy));
      end
      for (int i = 0; i < DEPTH; i++) begin
         chk($sformatf("rnd_bank%0d", i), 32'(bank[i]), 32'(m_bank[i]));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
